// File: rtl/if_pkg.sv
// Shared encodings and instruction field positions for the fetch stage.
package if_pkg;

    // Decoder Jump_o encoding (the value 2'b11 is never decoded and acts as sequential)
    localparam logic [1:0] JMP_J   = 2'b00;
    localparam logic [1:0] JMP_SEQ = 2'b01;
    localparam logic [1:0] JMP_JR  = 2'b10;

    // Decoder Branch_o encoding (anything other than BR_BEQ means no branch)
    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_BEQ  = 2'b01;

    // sll $0,$0,0 -- the bubble placed into IF/ID on flush or reset
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

    // Instruction field ranges
    localparam int OP_MSB     = 31;
    localparam int OP_LSB     = 26;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;
    localparam int TARGET_MSB = 25;
    localparam int TARGET_LSB = 0;

    // Branch target: base plus sign-extended word offset, wrapping mod 2^32
    function automatic logic [31:0] beqTarget(input logic [31:0] base, input logic [15:0] imm);
        return base + {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Redirect decode and target selection for the instruction held in IF/ID.
module pc_next_sel
    import if_pkg::*;
(
    input  logic        valid,
    input  logic        stall,
    input  logic [1:0]  jump,
    input  logic [1:0]  branch,
    input  logic        zero,
    input  logic [31:0] rsData,
    input  logic [25:0] instrLow,
    input  logic [31:0] pcPlus4,
    output logic        redirect,
    output logic [31:0] target
);

    logic isJ;
    logic isJr;
    logic brTaken;

    // Jump beats jr beats branch; a bubble or stalled cycle never redirects
    always_comb begin
        isJ      = (jump == JMP_J);
        isJr     = (jump == JMP_JR);
        brTaken  = (branch == BR_BEQ) && zero;
        redirect = valid && !stall && (isJ || isJr || brTaken);
        if (isJ)
            target = {pcPlus4[31:28], instrLow[TARGET_MSB:TARGET_LSB], 2'b00};
        else if (isJr)
            target = rsData & 32'hFFFF_FFFC;  // misaligned jr silently truncated
        else
            target = beqTarget(pcPlus4, instrLow[IMM_MSB:IMM_LSB]);
    end

endmodule

// File: rtl/instr_fetch_stage.sv
// PC register, next-PC selection and IF/ID register of the MIPS datapath.
// Define IF_PERF_CNT_EN to add fetch/flush event counters.
module instr_fetch_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_data_i,
    input  logic        stall_i,
    input  logic [1:0]  jump_i,
    input  logic [1:0]  branch_i,
    input  logic        zero_i,
    input  logic [31:0] rs_data_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_plus4_o,
    output logic        valid_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] flush_cnt_o
`endif
);

    logic [31:0] pcQ;
    logic [31:0] instrQ;
    logic [31:0] pcPlus4Q;
    logic        validQ;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] pcInc;

    assign pcInc = pcQ + 32'd4;  // wraps FFFF_FFFC -> 0

    pc_next_sel uNextSel (
        .valid    (validQ),
        .stall    (stall_i),
        .jump     (jump_i),
        .branch   (branch_i),
        .zero     (zero_i),
        .rsData   (rs_data_i),
        .instrLow (instrQ[25:0]),
        .pcPlus4  (pcPlus4Q),
        .redirect (redirect),
        .target   (target)
    );

    // PC and IF/ID update: redirect flushes, stall holds, otherwise fetch sequentially
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pcQ      <= RESET_PC;
            instrQ   <= NOP_INSTR;
            pcPlus4Q <= 32'd0;
            validQ   <= 1'b0;
        end else if (redirect) begin
            pcQ    <= target;
            instrQ <= NOP_INSTR;
            validQ <= 1'b0;
        end else if (!stall_i) begin
            pcQ      <= pcInc;
            instrQ   <= imem_data_i;
            pcPlus4Q <= pcInc;
            validQ   <= 1'b1;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetchCnt;
    logic [31:0] flushCnt;

    // Count sequential IF/ID loads and redirects
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetchCnt <= 32'd0;
            flushCnt <= 32'd0;
        end else if (redirect) begin
            flushCnt <= flushCnt + 32'd1;
        end else if (!stall_i) begin
            fetchCnt <= fetchCnt + 32'd1;
        end
    end

    assign fetch_cnt_o = fetchCnt;
    assign flush_cnt_o = flushCnt;
`else
    // No event counters in this build
`endif

    assign imem_addr_o = pcQ;
    assign pc_o        = pcQ;
    assign instr_o     = instrQ;
    assign pc_plus4_o  = pcPlus4Q;
    assign valid_o     = validQ;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed scenarios plus random redirect/stall traffic
// compared every cycle against a behavioural model of fetch.
module tb_instr_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imemAddr;
    logic [31:0] imemData;
    logic        stall;
    logic [1:0]  jump;
    logic [1:0]  branch;
    logic        zero;
    logic [31:0] rsData;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pcPlus4;
    logic        valid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetchCnt;
    logic [31:0] flushCnt;
`endif

    int nChecks = 0;
    int nFails  = 0;

    // ROM with one patchable word
    logic        ovrEn   = 1'b0;
    logic [31:0] ovrAddr = 32'd0;
    logic [31:0] ovrData = 32'd0;

    // Behavioural model state
    logic [31:0] mPc, mInstr, mPp4, mFetch, mFlush;
    logic        mValid;

    always #5 clk = ~clk;

    function automatic logic [31:0] hash(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    assign imemData = (ovrEn && imemAddr == ovrAddr) ? ovrData : hash(imemAddr);

    instr_fetch_stage dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .imem_addr_o (imemAddr),
        .imem_data_i (imemData),
        .stall_i     (stall),
        .jump_i      (jump),
        .branch_i    (branch),
        .zero_i      (zero),
        .rs_data_i   (rsData),
        .pc_o        (pc),
        .instr_o     (instr),
        .pc_plus4_o  (pcPlus4),
        .valid_o     (valid)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt_o (fetchCnt),
        .flush_cnt_o (flushCnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        nChecks++;
        if (got !== want) begin
            nFails++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic modelReset();
        mPc = 32'd0; mInstr = 32'd0; mPp4 = 32'd0; mValid = 1'b0;
        mFetch = 32'd0; mFlush = 32'd0;
    endtask

    // One clock edge of the fetch stage, from the rules rather than the RTL structure
    task automatic modelEdge();
        logic        taken;
        logic [31:0] tgt;
        logic [31:0] word;
        if (!rst) begin
            modelReset();
            return;
        end
        taken = mValid && !stall && (jump == 2'd0 || jump == 2'd2 || (branch == 2'd1 && zero));
        if (jump == 2'd0)
            tgt = (mPp4 & 32'hF000_0000) | ((mInstr & 32'h03FF_FFFF) * 4);
        else if (jump == 2'd2)
            tgt = rsData - (rsData % 4);
        else
            tgt = mPp4 + 32'($signed(mInstr[15:0]) * 4);
        if (taken) begin
            mPc = tgt; mInstr = 32'd0; mValid = 1'b0; mFlush = mFlush + 1;
        end else if (!stall) begin
            word = (ovrEn && mPc == ovrAddr) ? ovrData : hash(mPc);
            mInstr = word; mPc = mPc + 4; mPp4 = mPc; mValid = 1'b1; mFetch = mFetch + 1;
        end
    endtask

    task automatic compareAll();
        check("pc", pc, mPc);
        check("imem_addr", imemAddr, mPc);
        check("instr", instr, mInstr);
        check("pc_plus4", pcPlus4, mPp4);
        check("valid", 32'(valid), 32'(mValid));
`ifdef IF_PERF_CNT_EN
        check("fetch_cnt", fetchCnt, mFetch);
        check("flush_cnt", flushCnt, mFlush);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        compareAll();
    endtask

    task automatic setIdle();
        stall = 1'b0; jump = 2'b01; branch = 2'b00; zero = 1'b0; rsData = 32'd0;
    endtask

    // Reset held across one edge, released between edges
    task automatic doReset();
        rst = 1'b0;
        modelReset();
        setIdle();
        @(negedge clk);
        compareAll();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        setIdle();
        modelReset();
        repeat (2) @(negedge clk);
        check("reset pc", pc, 32'h0);
        check("reset instr", instr, 32'h0);
        check("reset pc_plus4", pcPlus4, 32'h0);
        check("reset valid", 32'(valid), 32'h0);

        // Sequential run from reset
        rst = 1'b1;
        tick();
        check("first pc", pc, 32'h4);
        check("first instr", instr, 32'h5A5A_1234);
        check("first valid", 32'(valid), 32'h1);
        repeat (4) tick();
        check("seq pc", pc, 32'h14);

        // j: target from pc_plus4 region and 26-bit index; bubble never redirects
        ovrEn = 1'b1; ovrAddr = 32'h0; ovrData = 32'h0800_0010;
        doReset();
        tick();
        check("j id instr", instr, 32'h0800_0010);
        jump = 2'b00;
        tick();
        check("j pc", pc, 32'h40);
        check("j bubble valid", 32'(valid), 32'h0);
        check("j bubble instr", instr, 32'h0);
        tick();
        check("bubble no redirect pc", pc, 32'h44);
        check("bubble refill valid", 32'(valid), 32'h1);

        // beq taken and not taken with a negative offset
        ovrAddr = 32'h1C; ovrData = 32'h1000_FFFE;
        doReset();
        repeat (8) tick();
        check("beq base", pcPlus4, 32'h20);
        branch = 2'b01; zero = 1'b1;
        tick();
        check("beq taken pc", pc, 32'h18);
        check("beq taken valid", 32'(valid), 32'h0);
        doReset();
        repeat (8) tick();
        branch = 2'b01; zero = 1'b0;
        tick();
        check("beq not taken pc", pc, 32'h24);
        check("beq not taken valid", 32'(valid), 32'h1);
        ovrEn = 1'b0;

        // jr held off by stall, then taken with low bits cleared
        doReset();
        tick();
        jump = 2'b10; rsData = 32'h0000_1237; stall = 1'b1;
        repeat (2) tick();
        check("stall pc hold", pc, 32'h4);
        check("stall valid hold", 32'(valid), 32'h1);
        stall = 1'b0;
        tick();
        check("jr pc", pc, 32'h1234);

        // Wrap at the top of the address space
        doReset();
        tick();
        jump = 2'b10; rsData = 32'hFFFF_FFF9;
        tick();
        check("jr high pc", pc, 32'hFFFF_FFF8);
        setIdle();
        tick();
        check("pre-wrap pc", pc, 32'hFFFF_FFFC);
        tick();
        check("wrap pc", pc, 32'h0);
        check("wrap pc_plus4", pcPlus4, 32'h0);

        // Asynchronous reset between edges
        tick();
        #2 rst = 1'b0;
        modelReset();
        #1;
        check("async pc", pc, 32'h0);
        check("async valid", 32'(valid), 32'h0);
        rst = 1'b1;
        tick();

`ifdef IF_PERF_CNT_EN
        doReset();
        repeat (9) tick();
        jump = 2'b10; rsData = 32'h100;
        tick();
        setIdle();
        tick();
        jump = 2'b10;
        tick();
        check("perf fetch", fetchCnt, 32'd10);
        check("perf flush", flushCnt, 32'd2);
        setIdle();
`endif

        // Random traffic
        doReset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                #2 rst = 1'b0;
                modelReset();
                #1 compareAll();
                rst = 1'b1;
            end
            stall  = ($urandom_range(0, 3) == 0);
            jump   = 2'($urandom);
            branch = 2'($urandom);
            zero   = 1'($urandom);
            rsData = $urandom;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
